// File: rtl/cache_mem_arbiter.sv
// Arbitrates i-cache and d-cache block misses onto one main-memory port.
// The granted request is latched, the memory busywait handshake is run, and a sticky watchdog flags slow memory.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic               timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, MEM_I, MEM_D, RESP_I, RESP_D} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;  // 1 = d-cache was granted last
  logic               op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic ireq;
  logic dreq;
  logic grant_d;

  assign ireq = i_read;
  assign dreq = d_read | d_write;
  // On a tie the side that was not granted last wins; reset leaves I as last, so D wins first.
  assign grant_d = dreq & (~ireq | ~last_grant_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = MEM_D;
          last_grant_d = 1'b1;
          op_wr_d      = d_write;
          addr_d       = d_address;
          wdata_d      = d_writedata;
          cnt_d        = '0;
        end else if (ireq) begin
          state_d      = MEM_I;
          last_grant_d = 1'b0;
          op_wr_d      = 1'b0;
          addr_d       = i_address;
          cnt_d        = '0;
        end
      end
      MEM_I, MEM_D: begin
        if (mem_busywait) begin
          // Saturating watchdog; the transaction keeps waiting even after the flag is raised.
          if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) err_d = 1'b1;
          end
        end else if (state_q == MEM_I) begin
          state_d   = RESP_I;
          i_rdata_d = mem_readdata;
        end else begin
          state_d = RESP_D;
          if (!op_wr_q) d_rdata_d = mem_readdata;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  assign mem_read      = ((state_q == MEM_I) || (state_q == MEM_D)) && !op_wr_q;
  assign mem_write     = (state_q == MEM_D) && op_wr_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign i_busywait    = ireq & (state_q != RESP_I);
  assign d_busywait    = dreq & (state_q != RESP_D);
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: one cycle per step, hand-computed expectations, a small memory model.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read, d_read, d_write;
  logic [27:0]  i_address, d_address;
  logic [127:0] d_writedata;
  logic [127:0] i_readdata, d_readdata;
  logic         i_busywait, d_busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic         mem_busywait;
  logic         timeout_err;

  int vectors_applied = 0;
  int miscompares     = 0;

  // Memory model: finishes after busy_n busy cycles, or never while stuck is set.
  int           busy_n = 0;
  logic         stuck  = 1'b0;
  logic [127:0] rdata  = '0;
  logic [7:0]   mcnt   = '0;
  logic         strobe;

  assign strobe       = mem_read | mem_write;
  assign mem_busywait = strobe & (stuck | (int'(mcnt) < busy_n));
  assign mem_readdata = mem_busywait ? ~rdata : rdata;

  always @(posedge clk) mcnt <= strobe ? mcnt + 8'd1 : 8'd0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(28), .BLOCK_W(128), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .timeout_err(timeout_err)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    stuck = 1'b0; busy_n = 0;
    #1;
    check_val("rst_mem_read", mem_read, 1'b0);
    check_val("rst_mem_write", mem_write, 1'b0);
    check_val("rst_i_readdata", i_readdata, '0);
    check_val("rst_d_readdata", d_readdata, '0);
    check_val("rst_timeout_err", timeout_err, 1'b0);
    check_val("rst_mem_address", mem_address, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] R1 = {4{32'h1111_0001}};
  localparam logic [127:0] R2 = {4{32'h2222_0002}};
  localparam logic [127:0] R3 = {4{32'h3333_0003}};
  localparam logic [127:0] R4 = {4{32'h4444_0004}};
  localparam logic [127:0] R5 = {4{32'h5555_0005}};
  localparam logic [127:0] WD = {4{32'hDEAD_BEEF}};

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pat;

    // Single i-cache read with 5 busy cycles.
    do_reset();
    cyc(); busy_n = 5; rdata = A5; i_read = 1'b1; i_address = 28'h0000010; #1;
    check_val("t1_c0_i_busywait", i_busywait, 1'b1);
    check_val("t1_c0_mem_read", mem_read, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      cyc(); #1;
      check_val("t1_mem_read", mem_read, 1'b1);
      check_val("t1_i_busywait", i_busywait, 1'b1);
      check_val("t1_mem_address", mem_address, 28'h0000010);
    end
    cyc(); #1;
    check_val("t1_c7_i_busywait", i_busywait, 1'b0);
    check_val("t1_c7_mem_read", mem_read, 1'b0);
    check_val("t1_c7_i_readdata", i_readdata, A5);
    cyc(); i_read = 1'b0; #1;
    check_val("t1_c8_i_busywait", i_busywait, 1'b0);
    cyc(); #1;
    check_val("t1_c9_idle", mem_read, 1'b0);
    check_val("t1_c9_hold", i_readdata, A5);
    $display("test 1: i-cache read, 5 busy cycles");

    // Simultaneous misses alternate, D first after reset.
    do_reset();
    cyc(); busy_n = 0; rdata = R1;
    i_read = 1'b1; i_address = 28'h100; d_read = 1'b1; d_address = 28'h200; #1;
    check_val("t2_c0_i_busywait", i_busywait, 1'b1);
    check_val("t2_c0_d_busywait", d_busywait, 1'b1);
    cyc(); #1;
    check_val("t2_c1_mem_read", mem_read, 1'b1);
    check_val("t2_c1_first_is_d", mem_address, 28'h200);
    cyc(); #1;
    check_val("t2_c2_d_busywait", d_busywait, 1'b0);
    check_val("t2_c2_i_busywait", i_busywait, 1'b1);
    check_val("t2_c2_d_readdata", d_readdata, R1);
    check_val("t2_c2_mem_read", mem_read, 1'b0);
    cyc(); d_address = 28'h300; rdata = R2; #1;
    check_val("t2_c3_idle", mem_read, 1'b0);
    cyc(); #1;
    check_val("t2_c4_second_is_i", mem_address, 28'h100);
    cyc(); #1;
    check_val("t2_c5_i_busywait", i_busywait, 1'b0);
    check_val("t2_c5_i_readdata", i_readdata, R2);
    check_val("t2_c5_d_busywait", d_busywait, 1'b1);
    cyc(); i_address = 28'h400; rdata = R3; #1;
    cyc(); #1;
    check_val("t2_c7_third_is_d", mem_address, 28'h300);
    cyc(); #1;
    check_val("t2_c8_d_readdata", d_readdata, R3);
    check_val("t2_c8_d_busywait", d_busywait, 1'b0);
    cyc(); d_read = 1'b0; #1;
    cyc(); #1;
    check_val("t2_c10_i_only", mem_address, 28'h400);
    cyc(); #1;
    check_val("t2_c11_i_busywait", i_busywait, 1'b0);
    cyc(); i_read = 1'b0;
    $display("test 2: alternating arbitration D, I, D, I");

    // d_read and d_write together give a writeback.
    cyc(); busy_n = 2; rdata = R4;
    d_read = 1'b1; d_write = 1'b1; d_address = 28'h1234567; d_writedata = WD; #1;
    check_val("t3_c0_mem_write", mem_write, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 2) d_writedata = '1;
      #1;
      check_val("t3_mem_write", mem_write, 1'b1);
      check_val("t3_mem_read", mem_read, 1'b0);
      check_val("t3_mem_writedata", mem_writedata, WD);
      check_val("t3_mem_address", mem_address, 28'h1234567);
    end
    cyc(); #1;
    check_val("t3_c4_d_busywait", d_busywait, 1'b0);
    check_val("t3_c4_d_readdata", d_readdata, R3);
    check_val("t3_c4_mem_write", mem_write, 1'b0);
    cyc(); d_read = 1'b0; d_write = 1'b0;
    $display("test 3: d-cache writeback");

    // Request dropped during MEM_D.
    cyc(); busy_n = 3; rdata = R5; d_read = 1'b1; d_address = 28'h55; #1;
    cyc(); #1;
    check_val("t4_c1_mem_read", mem_read, 1'b1);
    check_val("t4_c1_d_busywait", d_busywait, 1'b1);
    cyc(); d_read = 1'b0; #1;
    check_val("t4_c2_d_busywait", d_busywait, 1'b0);
    check_val("t4_c2_mem_read", mem_read, 1'b1);
    for (int c = 3; c <= 4; c++) begin
      cyc(); #1;
      check_val("t4_mem_read", mem_read, 1'b1);
      check_val("t4_d_busywait", d_busywait, 1'b0);
    end
    cyc(); #1;
    check_val("t4_c5_resp_strobe", mem_read, 1'b0);
    check_val("t4_c5_d_readdata", d_readdata, R5);
    check_val("t4_c5_d_busywait", d_busywait, 1'b0);
    cyc(); i_read = 1'b1; i_address = 28'h66; busy_n = 0; #1;
    check_val("t4_c6_idle", mem_read, 1'b0);
    cyc(); #1;
    check_val("t4_c7_mem_read", mem_read, 1'b1);
    check_val("t4_c7_mem_address", mem_address, 28'h66);
    cyc(); #1;
    check_val("t4_c8_i_busywait", i_busywait, 1'b0);
    check_val("t4_c8_timeout_err", timeout_err, 1'b0);
    cyc(); i_read = 1'b0;
    $display("test 4: dropped d-cache request");

    // Watchdog with memory stuck busy, then async reset mid-transaction.
    cyc(); d_read = 1'b1; d_address = 28'h77; stuck = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      cyc(); #1;
      check_val("t5_mem_read", mem_read, 1'b1);
      check_val("t5_timeout_err", timeout_err, (c >= 9) ? 1'b1 : 1'b0);
    end
    cyc(); stuck = 1'b0; #1;
    check_val("t5_c12_mem_read", mem_read, 1'b1);
    cyc(); #1;
    check_val("t5_c13_d_busywait", d_busywait, 1'b0);
    check_val("t5_c13_timeout_err", timeout_err, 1'b1);
    cyc(); d_read = 1'b0; #1;
    check_val("t5_c14_sticky", timeout_err, 1'b1);
    cyc(); i_read = 1'b1; i_address = 28'h99;
    cyc(); #1;
    check_val("t5_c16_mem_read", mem_read, 1'b1);
    reset = 1'b0; #1;
    check_val("t5_async_mem_read", mem_read, 1'b0);
    check_val("t5_async_timeout_err", timeout_err, 1'b0);
    check_val("t5_async_d_readdata", d_readdata, '0);
    check_val("t5_async_i_readdata", i_readdata, '0);
    check_val("t5_async_mem_address", mem_address, '0);
    $display("test 5: watchdog and async reset");

    // Back-to-back d misses, memory done in the first MEM cycle.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      cyc();
      busy_n = 0;
      d_read = 1'b1;
      d_address = 28'h1000 + 28'(c / 3);
      i_read = (c % 3 == 1);
      pat = {32'hC0DE_0000, 64'h0, 32'(c)};
      rdata = pat;
      #1;
      check_val("t6_d_busywait", d_busywait, (c % 3 != 2) ? 1'b1 : 1'b0);
      check_val("t6_mem_read", mem_read, (c % 3 == 1) ? 1'b1 : 1'b0);
      check_val("t6_i_busywait", i_busywait, (c % 3 == 1) ? 1'b1 : 1'b0);
      if (c % 3 == 1) check_val("t6_mem_address", mem_address, 28'h1000 + 28'(c / 3));
      if (c % 3 == 2) check_val("t6_d_readdata", d_readdata, {32'hC0DE_0000, 64'h0, 32'(c - 1)});
    end
    cyc(); d_read = 1'b0; i_read = 1'b0;
    cyc();
    $display("test 6: back-to-back d-cache misses");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
